mvm_axis_packer: RTL

//  Upstream feeder for the MVM tile. Takes a narrow host word stream (header + payload words) and

---
 rtl/mvm_axis_packer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mvm_axis_packer.sv
// mvm_axis_packer: collects a header word plus its payload words from a narrow
// host stream and emits them as one wide single-flit AXI-Stream packet. The MVM
// command fields from the header (RF address, op, RF select) travel on tuser.
`timescale 1ns/1ps
module mvm_axis_packer #(
    parameter int DATAW = 512,
    parameter int WORDW = 32,
    parameter int BYTEW = 8,
    parameter int IDW   = 32,
    parameter int DESTW = 12,
    parameter int USERW = 75
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WORDW-1:0] in_data,
    output logic             in_ready,
    output logic             axis_tx_tvalid,
    output logic [DATAW-1:0] axis_tx_tdata,
    output logic [BYTEW-1:0] axis_tx_tstrb,
    output logic [BYTEW-1:0] axis_tx_tkeep,
    output logic [IDW-1:0]   axis_tx_tid,
    output logic [DESTW-1:0] axis_tx_tdest,
    output logic [USERW-1:0] axis_tx_tuser,
    output logic             axis_tx_tlast,
    input  logic             axis_tx_tready,
    output logic             busy
);

    localparam int WORDS = DATAW / WORDW;
    localparam int CNTW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNTW-1:0] LAST_VEC = CNTW'(WORDS - 1);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  last_slot;
    logic [DATAW-1:0] payload;
    logic [USERW-1:0] tuser_reg;
    logic [USERW-1:0] hdr_user;
    logic [DESTW-1:0] tdest_reg;
    logic [IDW-1:0]   tid_reg;
    logic             tvalid_reg;
    logic             hdr_take;
    logic             pay_take;
    logic             last_take;
    logic             tx_done;

    // Header-to-tuser mapping: low 12 header bits verbatim, upper tuser bits zero.
    always_comb begin
        hdr_user       = '0;
        hdr_user[11:0] = in_data[11:0];
    end

    // Next state, host handshake and datapath enables. The op held in
    // tuser_reg[10:9] decides whether the packet carries one word or a full flit.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        hdr_take   = 1'b0;
        pay_take   = 1'b0;
        last_take  = 1'b0;
        tx_done    = 1'b0;
        last_slot  = (tuser_reg[10:9] == 2'b00) ? '0 : LAST_VEC;
        case (state)
            HDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hdr_take   = 1'b1;
                    state_next = PAY;
                end
            end
            PAY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pay_take = 1'b1;
                    if (cnt == last_slot) begin
                        last_take  = 1'b1;
                        state_next = SEND;
                    end
                end
            end
            SEND: begin
                if (tvalid_reg && axis_tx_tready) begin
                    tx_done    = 1'b1;
                    state_next = HDR;
                end
            end
            default: state_next = HDR;
        endcase
    end

    // State register; reset drops any partially collected packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HDR;
        end else begin
            state <= state_next;
        end
    end

    // Packet buffer and header fields. Nothing here changes in SEND, so the
    // flit contents stay stable for as long as the sink stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            payload   <= '0;
            tuser_reg <= '0;
            tdest_reg <= '0;
            cnt       <= '0;
        end else if (hdr_take) begin
            payload   <= '0;
            tuser_reg <= hdr_user;
            tdest_reg <= in_data[12 +: DESTW];
            cnt       <= '0;
        end else if (pay_take) begin
            payload[cnt*WORDW +: WORDW] <= in_data;
            if (!last_take) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Registered tvalid and the packet sequence number, which advances once per
    // completed handshake and wraps naturally at IDW bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tvalid_reg <= 1'b0;
            tid_reg    <= '0;
        end else if (last_take) begin
            tvalid_reg <= 1'b1;
        end else if (tx_done) begin
            tvalid_reg <= 1'b0;
            tid_reg    <= tid_reg + 1'b1;
        end
    end

    assign axis_tx_tvalid = tvalid_reg;
    assign axis_tx_tdata  = payload;
    assign axis_tx_tstrb  = '1;
    assign axis_tx_tkeep  = '1;
    assign axis_tx_tid    = tid_reg;
    assign axis_tx_tdest  = tdest_reg;
    assign axis_tx_tuser  = tuser_reg;
    assign axis_tx_tlast  = 1'b1;
    assign busy           = (state != HDR);

endmodule
